audio_splitter: RTL and testbench

Distributes one stereo sample stream to two independent destination channels, A and B, each with its own valid/ready handshake, per-channel attenuation and buffering. It is the fan-out counterpart of the stereo mixer: where the mixer sums channel A and channel B into one output, this block takes one stream and feeds both channel paths. Mixed/processed audio enters here, and the block feeds the two downstream sinks, e.g. the local DAC path and the network encoder path.

---
 rtl/audio_pkg.sv | 17 +
 rtl/audio_sample_fifo.sv | 69 ++++++
 rtl/audio_splitter.sv | 133 +++++++++++++
 tb/tb_audio_splitter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared constants and helpers for the stereo splitter datapath.
// Latency: n/a (types, constants and functions only).
// Backpressure: n/a.
package audio_pkg;

  localparam int SAMPLE_SIZE = 24;
  localparam int GAIN_W      = 2;
  localparam int DROP_W      = 16;

  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  // Saturating increment for the per-channel drop counters.
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == DROP_MAX) ? v : v + DROP_W'(1);
  endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// Per-channel stereo sample queue: one entry holds left and right together.
// Latency: a push is visible on o_rdat/o_vld the next cycle when the queue was empty.
// Backpressure: pops on o_vld && i_rdy; pushes are ignored while full; push+pop allowed when not full.
module audio_sample_fifo
  import audio_pkg::*;
#(
  parameter int W     = 2 * SAMPLE_SIZE,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_wdat,
  input  logic         i_rdy,
  output logic [W-1:0] o_rdat,
  output logic         o_vld,
  output logic         o_full,
  output logic         o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_vld   = !o_empty;
  assign w_pop   = o_vld && i_rdy;
  assign w_push  = i_push && !o_full;

  // Head entry is forced to zero while empty so idle outputs read as silence.
  assign o_rdat = o_vld ? r_mem[r_rd_ptr] : '0;

  // Storage write; contents need no reset because the occupancy counter gates reads.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdat;
    end
  end

  // Pointers wrap naturally modulo DEPTH; occupancy tracks push/pop balance.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/audio_splitter.sv
// Fans one stereo stream out to channels A and B with per-channel gain/mute and queueing.
// Latency: accepted sample reaches an empty channel's outputs one cycle later.
// Backpressure: lockstep stalls in_ready on any full channel; drop mode always ready and counts discards.
module audio_splitter
  import audio_pkg::*;
#(
  parameter int SIZE  = SAMPLE_SIZE,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SIZE-1:0]   in_left,
  input  logic [SIZE-1:0]   in_right,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              drop_mode,
  input  logic [GAIN_W-1:0] a_gain,
  input  logic [GAIN_W-1:0] b_gain,
  input  logic              a_mute,
  input  logic              b_mute,
  output logic [SIZE-1:0]   a_left,
  output logic [SIZE-1:0]   a_right,
  output logic [SIZE-1:0]   b_left,
  output logic [SIZE-1:0]   b_right,
  output logic              a_valid,
  output logic              b_valid,
  input  logic              a_ready,
  input  logic              b_ready,
  output logic [DROP_W-1:0] a_drops,
  output logic [DROP_W-1:0] b_drops
);

  // Sign-preserving attenuation; mute overrides gain.
  function automatic logic [SIZE-1:0] scale(input logic [SIZE-1:0]   s,
                                            input logic [GAIN_W-1:0] g,
                                            input logic              m);
    logic signed [SIZE-1:0] v;
    v = $signed(s) >>> g;
    return m ? '0 : v;
  endfunction

  logic              r_drop_mode;
  logic [DROP_W-1:0] r_a_drops;
  logic [DROP_W-1:0] r_b_drops;

  logic              w_accept;
  logic              w_a_full;
  logic              w_b_full;
  logic              w_a_empty;
  logic              w_b_empty;
  logic              w_a_push;
  logic              w_b_push;
  logic [SIZE-1:0]   w_a_l;
  logic [SIZE-1:0]   w_a_r;
  logic [SIZE-1:0]   w_b_l;
  logic [SIZE-1:0]   w_b_r;
  logic [2*SIZE-1:0] w_a_rdat;
  logic [2*SIZE-1:0] w_b_rdat;

  // Ready is built only from registered full flags and the registered mode bit,
  // so downstream ready never reaches in_ready combinationally.
  assign in_ready = !reset && (r_drop_mode || (!w_a_full && !w_b_full));
  assign w_accept = in_valid && in_ready;
  assign w_a_push = w_accept && !w_a_full;
  assign w_b_push = w_accept && !w_b_full;

  assign w_a_l = scale(in_left,  a_gain, a_mute);
  assign w_a_r = scale(in_right, a_gain, a_mute);
  assign w_b_l = scale(in_left,  b_gain, b_mute);
  assign w_b_r = scale(in_right, b_gain, b_mute);

  assign a_left  = w_a_rdat[2*SIZE-1:SIZE];
  assign a_right = w_a_rdat[SIZE-1:0];
  assign b_left  = w_b_rdat[2*SIZE-1:SIZE];
  assign b_right = w_b_rdat[SIZE-1:0];
  assign a_drops = r_a_drops;
  assign b_drops = r_b_drops;

  // Mode change applies from the next cycle's in_ready; queued samples are kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop_mode <= 1'b0;
    end else begin
      r_drop_mode <= drop_mode;
    end
  end

  // An accepted sample landing on a full channel is a drop (only reachable in drop mode).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_drops <= '0;
      r_b_drops <= '0;
    end else begin
      if (w_accept && w_a_full) begin
        r_a_drops <= sat_inc(r_a_drops);
      end
      if (w_accept && w_b_full) begin
        r_b_drops <= sat_inc(r_b_drops);
      end
    end
  end

  audio_sample_fifo #(
    .W     (2 * SIZE),
    .DEPTH (DEPTH)
  ) u_fifo_a (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_a_push),
    .i_wdat  ({w_a_l, w_a_r}),
    .i_rdy   (a_ready),
    .o_rdat  (w_a_rdat),
    .o_vld   (a_valid),
    .o_full  (w_a_full),
    .o_empty (w_a_empty)
  );

  audio_sample_fifo #(
    .W     (2 * SIZE),
    .DEPTH (DEPTH)
  ) u_fifo_b (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_b_push),
    .i_wdat  ({w_b_l, w_b_r}),
    .i_rdy   (b_ready),
    .o_rdat  (w_b_rdat),
    .o_vld   (b_valid),
    .o_full  (w_b_full),
    .o_empty (w_b_empty)
  );

endmodule

// File: tb/tb_audio_splitter.sv
// Directed, self-checking bench for audio_splitter.
// Latency: n/a.
// Backpressure: n/a.
module tb_audio_splitter;
  import audio_pkg::*;

  localparam int SIZE  = 24;
  localparam int DEPTH = 4;
  localparam int NV    = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic [SIZE-1:0]   in_left, in_right;
  logic              in_valid, in_ready, drop_mode;
  logic [GAIN_W-1:0] a_gain, b_gain;
  logic              a_mute, b_mute;
  logic [SIZE-1:0]   a_left, a_right, b_left, b_right;
  logic              a_valid, b_valid, a_ready, b_ready;
  logic [DROP_W-1:0] a_drops, b_drops;

  always #5 clk = ~clk;

  audio_splitter #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_left(in_left), .in_right(in_right), .in_valid(in_valid), .in_ready(in_ready),
    .drop_mode(drop_mode), .a_gain(a_gain), .b_gain(b_gain), .a_mute(a_mute), .b_mute(b_mute),
    .a_left(a_left), .a_right(a_right), .b_left(b_left), .b_right(b_right),
    .a_valid(a_valid), .b_valid(b_valid), .a_ready(a_ready), .b_ready(b_ready),
    .a_drops(a_drops), .b_drops(b_drops)
  );

  typedef struct {
    logic [SIZE-1:0] l, r;
    logic [1:0]      ag, bg;
    logic            am, bm;
    logic [SIZE-1:0] al, ar, bl, br;
  } vec_t;

  vec_t tbl [NV];

  int total = 0;
  int bad   = 0;
  int acc_cnt;
  bit rec_en;
  logic [SIZE-1:0] qa_l[$], qa_r[$], qb_l[$], qb_r[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [SIZE-1:0] smp_l(input int k);
    return 24'h000010 + 24'(k);
  endfunction

  function automatic logic [SIZE-1:0] smp_r(input int k);
    return 24'hF00000 + 24'(k);
  endfunction

  task automatic drive(input int k);
    in_left  = smp_l(k);
    in_right = smp_r(k);
  endtask

  task automatic clear_q();
    qa_l.delete(); qa_r.delete(); qb_l.delete(); qb_r.delete();
  endtask

  // One clock: observe handshakes mid-cycle, then step to just past the edge.
  task automatic tick();
    @(negedge clk);
    if (in_valid && in_ready) acc_cnt++;
    if (rec_en) begin
      if (a_valid && a_ready) begin qa_l.push_back(a_left); qa_r.push_back(a_right); end
      if (b_valid && b_ready) begin qb_l.push_back(b_left); qb_r.push_back(b_right); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_ch(input string nm, input bit is_b, input int n);
    int sz;
    sz = is_b ? qb_l.size() : qa_l.size();
    chk({nm, " count"}, sz, n);
    for (int i = 0; i < n && i < sz; i++) begin
      chk({nm, " left"},  is_b ? qb_l[i] : qa_l[i], smp_l(i));
      chk({nm, " right"}, is_b ? qb_r[i] : qa_r[i], smp_r(i));
    end
  endtask

  initial begin
    tbl[0] = '{24'h000100, 24'hFFFF00, 2'd0, 2'd0, 1'b0, 1'b0, 24'h000100, 24'hFFFF00, 24'h000100, 24'hFFFF00};
    tbl[1] = '{24'h800000, 24'h000040, 2'd2, 2'd0, 1'b0, 1'b1, 24'hE00000, 24'h000010, 24'h000000, 24'h000000};
    tbl[2] = '{24'h7FFFFF, 24'hFFFFFF, 2'd3, 2'd3, 1'b0, 1'b0, 24'h0FFFFF, 24'hFFFFFF, 24'h0FFFFF, 24'hFFFFFF};
    tbl[3] = '{24'h123456, 24'hFEDCBA, 2'd1, 2'd3, 1'b0, 1'b0, 24'h091A2B, 24'hFF6E5D, 24'h02468A, 24'hFFDB97};
    tbl[4] = '{24'h000001, 24'h800000, 2'd0, 2'd0, 1'b1, 1'b0, 24'h000000, 24'h000000, 24'h000001, 24'h800000};
    tbl[5] = '{24'hFFFFFF, 24'h000001, 2'd1, 2'd1, 1'b0, 1'b0, 24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'h000000};

    reset = 1'b1; in_valid = 1'b0; in_left = '0; in_right = '0; drop_mode = 1'b0;
    a_gain = '0; b_gain = '0; a_mute = 1'b0; b_mute = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
    rec_en = 1'b0; acc_cnt = 0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst in_ready", in_ready, 0);
    chk("rst a_valid", a_valid, 0);
    chk("rst b_valid", b_valid, 0);
    chk("rst a_left", a_left, 0);
    chk("rst b_right", b_right, 0);
    chk("rst a_drops", a_drops, 0);
    chk("rst b_drops", b_drops, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post-rst in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Table vectors back to back: one-cycle latency and full throughput
    for (int i = 0; i <= NV; i++) begin
      if (i < NV) begin
        in_valid = 1'b1; in_left = tbl[i].l; in_right = tbl[i].r;
        a_gain = tbl[i].ag; b_gain = tbl[i].bg; a_mute = tbl[i].am; b_mute = tbl[i].bm;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (i < NV) chk("tbl in_ready", in_ready, 1);
      if (i > 0) begin
        chk("tbl a_valid", a_valid, 1);
        chk("tbl b_valid", b_valid, 1);
        chk("tbl a_left",  a_left,  tbl[i-1].al);
        chk("tbl a_right", a_right, tbl[i-1].ar);
        chk("tbl b_left",  b_left,  tbl[i-1].bl);
        chk("tbl b_right", b_right, tbl[i-1].br);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("tbl idle a_valid", a_valid, 0);
    chk("tbl idle b_valid", b_valid, 0);
    @(posedge clk); #1;
    a_gain = '0; b_gain = '0; a_mute = 1'b0; b_mute = 1'b0;

    // Lockstep backpressure
    b_ready = 1'b0; clear_q(); rec_en = 1'b1; acc_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid = (acc_cnt < 6); drive(acc_cnt);
      tick();
    end
    chk("lock accepted", acc_cnt, 4);
    chk("lock stalled in_ready", in_ready, 0);
    check_ch("lock A first", 1'b0, 4);
    b_ready = 1'b1;
    chk("lock in_ready in pop cycle", in_ready, 0);
    tick();
    chk("lock in_ready after pop", in_ready, 1);
    for (int c = 0; c < 40; c++) begin
      in_valid = (acc_cnt < 6); drive(acc_cnt);
      tick();
      if (acc_cnt == 6 && qa_l.size() == 6 && qb_l.size() == 6) break;
    end
    in_valid = 1'b0;
    check_ch("lock A", 1'b0, 6);
    check_ch("lock B", 1'b1, 6);

    // Drop mode
    reset = 1'b1; tick(); reset = 1'b0;
    drop_mode = 1'b1; b_ready = 1'b0; a_ready = 1'b1; clear_q(); acc_cnt = 0;
    tick();
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1; drive(acc_cnt);
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    chk("drop accepted", acc_cnt, 10);
    check_ch("drop A", 1'b0, 10);
    chk("drop b_drops", b_drops, 6);
    chk("drop a_drops", a_drops, 0);
    b_ready = 1'b1; clear_q();
    repeat (6) tick();
    check_ch("drop B", 1'b1, 4);
    chk("drop B empty", b_valid, 0);

    // Drop counter saturation: 4 fill B, then 70000 drops on top of 6
    rec_en = 1'b0; b_ready = 1'b0; in_valid = 1'b1; drive(0);
    repeat (65532) @(posedge clk);
    #1;
    chk("sat below max", b_drops, 16'hFFFE);
    @(posedge clk); #1;
    chk("sat at max", b_drops, 16'hFFFF);
    repeat (4471) @(posedge clk);
    #1;
    chk("sat held", b_drops, 16'hFFFF);
    chk("sat a_drops", a_drops, 0);

    // Reset mid-stream with both channels holding samples
    a_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("mid a_valid before", a_valid, 1);
    chk("mid b_valid before", b_valid, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid rst a_valid", a_valid, 0);
    chk("mid rst b_valid", b_valid, 0);
    chk("mid rst a_drops", a_drops, 0);
    chk("mid rst b_drops", b_drops, 0);
    chk("mid rst in_ready", in_ready, 0);
    reset = 1'b0; #1;
    chk("mid post in_ready", in_ready, 1);

    // Simultaneous push/pop at occupancy 2
    drop_mode = 1'b0; a_ready = 1'b0; b_ready = 1'b0; clear_q(); rec_en = 1'b1; acc_cnt = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; drive(0); tick();
    drive(1); tick();
    a_ready = 1'b1; b_ready = 1'b1; drive(2); tick();
    a_ready = 1'b0; b_ready = 1'b0; drive(3); tick();
    drive(4); tick();
    in_valid = 1'b0;
    chk("pp accepted", acc_cnt, 5);
    chk("pp full in_ready", in_ready, 0);
    a_ready = 1'b1; b_ready = 1'b1;
    repeat (6) tick();
    check_ch("pp A", 1'b0, 5);
    check_ch("pp B", 1'b1, 5);
    chk("pp a_valid end", a_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
